// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data memory responder: MMIO map, STATUS layout,
// default sizing, and the STATUS word packer.
package data_mem_responder_pkg;

   localparam int unsigned DEFAULT_RAM_WORDS  = 256;
   localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

   localparam logic [31:0] ADDR_OUT_DATA = 32'hFFFF_0000;
   localparam logic [31:0] ADDR_STATUS   = 32'hFFFF_0004;
   localparam logic [31:0] ADDR_CYCLE    = 32'hFFFF_0008;

   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_OVERFLOW  = 2;
   localparam int STAT_MISALIGN  = 3;
   localparam int STAT_COUNT_LSB = 4;
   localparam int STAT_COUNT_W   = 4;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_OUT_DATA,
      SEL_STATUS,
      SEL_CYCLE
   } sel_e;

   function automatic logic [31:0] status_word(
      input logic                    full,
      input logic                    empty,
      input logic                    overflow,
      input logic                    misalign,
      input logic [STAT_COUNT_W-1:0] count
   );
      logic [31:0] w;
      w = '0;
      w[STAT_FULL]     = full;
      w[STAT_EMPTY]    = empty;
      w[STAT_OVERFLOW] = overflow;
      w[STAT_MISALIGN] = misalign;
      w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
      return w;
   endfunction

endpackage

// File: rtl/data_mem_responder_out_fifo.sv
// Output FIFO for MMIO OUT_DATA writes. A push into a full FIFO is only
// accepted when a pop happens in the same cycle; the caller flags the drop.
module out_fifo
   import data_mem_responder_pkg::*;
#(
   parameter  int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [31:0]      push_data,
   output logic [31:0]      head_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [31:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = empty ? 32'h0 : mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_comb begin
      push_ok  = push && (!full || pop);
      pop_ok   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (rst) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
   end

   // Entry storage; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Single-cycle CPU data-side responder: word RAM, OUT_DATA FIFO, STATUS with
// sticky W1C error flags, and a free-running writable CYCLE counter.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned RAM_WORDS  = DEFAULT_RAM_WORDS,
   parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] rd_data,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err
);

   localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]       ram_q [RAM_WORDS];
   logic [31:0]       cycle_q, cycle_d;
   logic              overflow_q, overflow_d;
   logic              misalign_q, misalign_d;
   logic              err_q, err_d;

   sel_e              sel;
   logic              aligned;
   logic              wr_en;
   logic [RAM_AW-1:0] ram_idx;
   logic              fifo_push, fifo_pop;
   logic              fifo_full, fifo_empty;
   logic [31:0]       fifo_head;
   logic [CNT_W-1:0]  fifo_count;

   assign aligned = (addr[1:0] == 2'b00);
   assign wr_en   = mem_write && !rst;
   assign ram_idx = addr[RAM_AW+1:2];

   // Address decode; misaligned addresses select nothing.
   always_comb begin
      sel = SEL_NONE;
      if (aligned) begin
         if (addr[31:RAM_AW+2] == '0)   sel = SEL_RAM;
         else if (addr == ADDR_OUT_DATA) sel = SEL_OUT_DATA;
         else if (addr == ADDR_STATUS)   sel = SEL_STATUS;
         else if (addr == ADDR_CYCLE)    sel = SEL_CYCLE;
      end
   end

   // Combinational read path; returns the pre-write value on read+write.
   always_comb begin
      rd_data = 32'h0;
      if (mem_read && !rst) begin
         case (sel)
            SEL_RAM:    rd_data = ram_q[ram_idx];
            SEL_STATUS: rd_data = status_word(fifo_full, fifo_empty, overflow_q,
                                              misalign_q, STAT_COUNT_W'(fifo_count));
            SEL_CYCLE:  rd_data = cycle_q;
            default:    rd_data = 32'h0;
         endcase
      end
   end

   assign fifo_push = wr_en && (sel == SEL_OUT_DATA);
   assign fifo_pop  = out_valid && out_ready;

   out_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_data (wr_data),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_valid = !fifo_empty && !rst;
   assign out_data  = out_valid ? fifo_head : 32'h0;
   assign err       = err_q && !rst;

   // Sticky flags (set wins over W1C), CYCLE counter, and registered err.
   always_comb begin
      logic ovf_set, mis_set, ovf_clr, mis_clr, status_wr;
      status_wr  = wr_en && (sel == SEL_STATUS);
      ovf_set    = fifo_push && fifo_full && !fifo_pop;
      mis_set    = !rst && (mem_read || mem_write) && !aligned;
      ovf_clr    = status_wr && wr_data[STAT_OVERFLOW];
      mis_clr    = status_wr && wr_data[STAT_MISALIGN];
      overflow_d = (overflow_q && !ovf_clr) || ovf_set;
      misalign_d = (misalign_q && !mis_clr) || mis_set;
      cycle_d    = (wr_en && (sel == SEL_CYCLE)) ? wr_data : cycle_q + 32'd1;
      if (rst) begin
         overflow_d = 1'b0;
         misalign_d = 1'b0;
         cycle_d    = 32'h0;
      end
      err_d = overflow_d || misalign_d;
   end

   // Status and counter registers.
   always_ff @(posedge clk) begin
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
      cycle_q    <= cycle_d;
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && (sel == SEL_RAM)) ram_q[ram_idx] <= wr_data;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed scenarios followed by
// randomized traffic, checked against a queue-based behavioural model.
module tb_data_mem_responder;

   localparam int DEPTH = 4;
   localparam logic [31:0] A_OUT  = 32'hFFFF_0000;
   localparam logic [31:0] A_STAT = 32'hFFFF_0004;
   localparam logic [31:0] A_CYC  = 32'hFFFF_0008;

   logic        clk = 1'b0;
   logic        rst, mem_read, mem_write, out_ready;
   logic [31:0] addr, wr_data;
   logic [31:0] rd_data, out_data;
   logic        out_valid, err;

   always #5 clk = ~clk;

   data_mem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .wr_data   (wr_data),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err)
   );

   int checks = 0;
   int passed = 0;

   typedef struct {
      bit          chk_rd;
      logic [31:0] rd;
      logic        err;
      logic        ov;
      logic [31:0] od;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pop_q[$];

   // reference model state
   logic [31:0] fifo_m[$];
   logic [31:0] ram_m[int];
   logic [31:0] cyc_m;
   bit          ovf_m, mis_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
      int n;
      known = 1'b1;
      n = fifo_m.size();
      if (a % 4 != 0) return 32'h0;
      if (a < 32'd1024) begin
         if (ram_m.exists(int'(a / 4))) return ram_m[int'(a / 4)];
         known = 1'b0;
         return 32'h0;
      end
      if (a == A_STAT)
         return 32'((n == DEPTH) + 2 * (n == 0) + 4 * ovf_m + 8 * mis_m + 16 * n);
      if (a == A_CYC) return cyc_m;
      return 32'h0;
   endfunction

   // One clock cycle: drive, record expectations, then commit the model at the edge.
   task automatic step(input bit r, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d, input bit rdy);
      exp_t        e;
      bit          known, popping, aligned, ovf_set, mis_set, load;
      logic [31:0] clr;
      int          pre;
      rst = r; mem_read = rd; mem_write = wr; addr = a; wr_data = d; out_ready = rdy;
      e.chk_rd = rd;
      e.rd     = 32'h0;
      if (!r && rd) begin
         e.rd     = model_read(a, known);
         e.chk_rd = known;
      end
      e.err = r ? 1'b0 : (ovf_m || mis_m);
      e.ov  = !r && (fifo_m.size() > 0);
      e.od  = e.ov ? fifo_m[0] : 32'h0;
      exp_q.push_back(e);
      popping = e.ov && rdy;
      if (popping) pop_q.push_back(fifo_m[0]);
      @(posedge clk);
      if (r) begin
         fifo_m.delete();
         ovf_m = 1'b0;
         mis_m = 1'b0;
         cyc_m = 32'h0;
      end else begin
         ovf_set = 1'b0; mis_set = 1'b0; load = 1'b0; clr = 32'h0;
         pre     = fifo_m.size();
         aligned = (a % 4 == 0);
         if ((rd || wr) && !aligned) mis_set = 1'b1;
         if (popping) void'(fifo_m.pop_front());
         if (wr && aligned) begin
            if (a < 32'd1024) ram_m[int'(a / 4)] = d;
            else if (a == A_OUT) begin
               if (pre < DEPTH || popping) fifo_m.push_back(d);
               else ovf_set = 1'b1;
            end
            else if (a == A_STAT) clr = d;
            else if (a == A_CYC) load = 1'b1;
         end
         ovf_m = (ovf_m && !clr[2]) || ovf_set;
         mis_m = (mis_m && !clr[3]) || mis_set;
         cyc_m = load ? d : cyc_m + 32'd1;
      end
      #1;
   endtask

   // Monitor: compares whatever the DUT presents against queued expectations.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (mem_read && e.chk_rd) chk("rd_data", rd_data, e.rd);
            chk("err", {31'h0, err}, {31'h0, e.err});
            chk("out_valid", {31'h0, out_valid}, {31'h0, e.ov});
            chk("out_data", out_data, e.od);
            chk("ctrl_known", {31'h0, $isunknown({out_valid, err})}, 32'h0);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
               if (pop_q.size() == 0) begin
                  checks++;
                  $display("FAIL pop_data: handshake got %h expected no pop at %0t", out_data, $time);
               end else begin
                  chk("pop_data", out_data, pop_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] a, d;
      bit          r, rd, wr, rdy;
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; out_ready = 1'b0;
      addr = 32'h0; wr_data = 32'h0; cyc_m = 32'h0; ovf_m = 1'b0; mis_m = 1'b0;
      @(posedge clk); #1;
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, A_CYC, 0, 0);

      // RAM write then same-cycle read; untouched word
      step(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0);
      step(0, 1, 0, 32'h10, 0, 0);
      step(0, 1, 0, 32'h14, 0, 0);
      step(0, 1, 1, 32'h10, 32'h1234_5678, 0);
      step(0, 1, 0, 32'h10, 0, 0);
      step(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0);

      // overflow with consumer stalled, drain, W1C
      for (int i = 1; i <= 5; i++) step(0, 0, 1, A_OUT, 32'(i), 0);
      step(0, 1, 0, A_STAT, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
      step(0, 0, 1, A_STAT, 32'h4, 0);
      step(0, 1, 0, A_STAT, 0, 0);

      // full FIFO with simultaneous push and pop
      for (int i = 5; i <= 8; i++) step(0, 0, 1, A_OUT, 32'(i), 0);
      step(0, 0, 1, A_OUT, 32'd9, 1);
      step(0, 1, 0, A_STAT, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

      // CYCLE load and wrap
      step(0, 0, 1, A_CYC, 32'hFFFF_FFFE, 0);
      step(0, 1, 0, A_CYC, 0, 0);
      step(0, 1, 0, A_CYC, 0, 0);
      step(0, 1, 0, A_CYC, 0, 0);

      // misaligned store
      step(0, 0, 1, 32'h12, 32'h5555_AAAA, 0);
      step(0, 1, 0, 32'h10, 0, 0);
      step(0, 1, 0, A_STAT, 0, 0);
      step(0, 0, 1, A_STAT, 32'h8, 0);

      // reset with entries queued
      for (int i = 0; i < 3; i++) step(0, 0, 1, A_OUT, 32'hA0 + 32'(i), 0);
      step(1, 0, 1, A_OUT, 32'hBB, 0);
      step(0, 1, 0, A_CYC, 0, 0);
      step(0, 1, 0, A_STAT, 0, 0);

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               a = 32'($urandom_range(0, 15)) << 2;
               if ($urandom_range(0, 7) == 0) a = 32'h3FC;
               if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
            end
            4, 5:    a = A_OUT;
            6:       a = A_STAT;
            7:       a = A_CYC;
            8: begin
               case ($urandom_range(0, 2))
                  0:       a = 32'h400;
                  1:       a = 32'hFFFF_000C;
                  default: a = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
               endcase
            end
            default: a = 32'hFFFF_0000 | 32'($urandom_range(1, 11));
         endcase
         d = $urandom;
         if (a == A_STAT && $urandom_range(0, 1) == 0) d = d & ~32'hC;
         rd  = ($urandom_range(0, 1) == 1);
         wr  = ($urandom_range(0, 1) == 1);
         rdy = ($urandom_range(0, 4) < 2);
         r   = ($urandom_range(0, 199) == 0);
         step(r, rd, wr, a, d, rdy);
      end
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
      chk("pending_pops", 32'(pop_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL have parameter RAM_WORDS, default 256, giving the number of 32-bit RAM words, power of two.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO entry count, power of two.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port addr, input, 32 bits: the CPU data byte address.
REQ-006 The module SHALL have port wr_data, input, 32 bits: the CPU store data.
REQ-007 The module SHALL have port mem_read, input, 1 bit: the CPU load request.
REQ-008 The module SHALL have port mem_write, input, 1 bit: the CPU store request.
REQ-009 The module SHALL have port rd_data, output, 32 bits: the load data returned to the CPU.
REQ-010 The module SHALL have port out_data, output, 32 bits: the FIFO head word.
REQ-011 The module SHALL have port out_valid, output, 1 bit: asserted while the FIFO is non-empty.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the head word.
REQ-013 The module SHALL have port err, output, 1 bit: the OR of the sticky error flags.

Function
REQ-014 The address map SHALL be: RAM at 0x0000_0000 to 4*RAM_WORDS-1; OUT_DATA at 0xFFFF_0000; STATUS at 0xFFFF_0004; CYCLE at 0xFFFF_0008; all other addresses unmapped.
REQ-015 Reads SHALL be combinational, with rd_data valid in the same cycle as mem_read, because the CPU is single-cycle.
REQ-016 rd_data SHALL be 0 when mem_read=0 or the address is unmapped.
REQ-017 Writes SHALL commit at the rising edge that ends the cycle with mem_write=1.
REQ-018 When mem_read=1 and mem_write=1 in the same cycle, rd_data SHALL return the pre-write value and the write SHALL commit.
REQ-019 RAM SHALL be word-indexed by addr[log2(RAM_WORDS)+1:2].
REQ-020 An access with addr[1:0]!=0 SHALL have no effect, SHALL return rd_data=0, and SHALL set sticky MISALIGN.
REQ-021 Writes to unmapped addresses and to OUT_DATA reads SHALL be ignored, with reads returning 0.
REQ-022 A write to OUT_DATA SHALL push wr_data into the FIFO.
REQ-023 A push while the FIFO is full with no simultaneous pop SHALL drop the data and set sticky OVERFLOW.
REQ-024 A pop SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-025 A simultaneous push and pop SHALL be accepted, including when the FIFO is full, leaving the count unchanged.
REQ-026 A simultaneous push and pop when empty SHALL NOT occur, since out_valid=0; the push alone SHALL be accepted.
REQ-027 out_data SHALL equal the head entry; it SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 STATUS read SHALL return: bit0 full; bit1 empty; bit2 OVERFLOW; bit3 MISALIGN; bits[7:4] count; other bits 0.
REQ-030 A STATUS write SHALL clear each sticky bit whose wr_data bit is 1 (write-1-to-clear).
REQ-031 A sticky bit being set and cleared in the same cycle SHALL end up set.
REQ-032 CYCLE SHALL increment by 1 every cycle and wrap from 0xFFFF_FFFF to 0.
REQ-033 A CYCLE write SHALL load wr_data, which SHALL read back the following cycle, with increments resuming after that.
REQ-034 err SHALL equal OVERFLOW OR MISALIGN, registered.

Reset
REQ-035 While rst=1, the FIFO SHALL be emptied, with out_valid=0 and out_data=0.
REQ-036 While rst=1, CYCLE SHALL be 0, the sticky flags SHALL be 0, and err SHALL be 0.
REQ-037 RAM contents SHALL NOT be reset.
REQ-038 Writes presented during a rst=1 cycle SHALL be discarded, and rd_data SHALL be 0 during reset.
REQ-039 Reset asserted mid-stream SHALL discard all queued FIFO entries.

Structure
REQ-040 A shared package SHALL hold the MMIO address constants, the STATUS bit positions, and the default parameter values.
REQ-041 The FIFO SHALL be a sub-module named out_fifo with push/pop/full/empty/count; the RAM, decode, and CYCLE SHALL remain in the top level.

Verification
REQ-042 The bench SHALL check RAM: write 0xDEADBEEF to 0x10, then read 0x10 -> rd_data=0xDEADBEEF in the same cycle; read 0x14 untouched -> no X on the control path.
REQ-043 The bench SHALL check overflow: with out_ready=0, push 5 words 1..5 -> STATUS=0x0000_0045 (count 4, full, overflow); drain -> out_data 1,2,3,4 in order; then write STATUS 0x4 -> bit2 clears.
REQ-044 The bench SHALL check full-FIFO push+pop: with the FIFO full and out_ready=1, push 9 -> count stays 4, no overflow, and 9 emerges last.
REQ-045 The bench SHALL check CYCLE: write 0xFFFF_FFFE, then read on the next cycle -> 0xFFFF_FFFE; two cycles later -> 0x0000_0000.
REQ-046 The bench SHALL check misalignment: write to 0x12 -> RAM unchanged, MISALIGN=1, and err=1 the next cycle.
REQ-047 The bench SHALL check reset mid-stream: with 3 entries queued, rst=1 for one cycle -> out_valid=0, STATUS=0x0000_0002, CYCLE=0.
